// File: rtl/jtkicker_objdraw_if.sv
// Bundle of signals around the Kicker sprite line drawer.
//   command side : draw, code, xpos, ysub, hflip, vflip, pal -> busy
//   ROM side     : rom_addr, rom_cs -> rom_data, rom_ok (jtframe_rom handshake)
//   buffer side  : buf_addr, buf_din, buf_we (object line-buffer write port)
// modport slave  : the drawer (jtkicker_objdraw)
// modport master : everything around it (scanner, ROM slot, line buffer)
interface jtkicker_objdraw_if #(
    parameter int PALW  = 4,
    parameter int CODEW = 10
);
    logic                 draw;
    logic [CODEW-1:0]     code;
    logic [7:0]           xpos;
    logic [3:0]           ysub;
    logic                 hflip;
    logic                 vflip;
    logic [PALW-1:0]      pal;
    logic                 busy;

    logic [CODEW+6:0]     rom_addr;
    logic                 rom_cs;
    logic [7:0]           rom_data;
    logic                 rom_ok;

    logic [7:0]           buf_addr;
    logic [PALW+3:0]      buf_din;
    logic                 buf_we;

    modport slave (
        input  draw, code, xpos, ysub, hflip, vflip, pal,
        output busy,
        output rom_addr, rom_cs,
        input  rom_data, rom_ok,
        output buf_addr, buf_din, buf_we
    );

    modport master (
        output draw, code, xpos, ysub, hflip, vflip, pal,
        input  busy,
        input  rom_addr, rom_cs,
        output rom_data, rom_ok,
        input  buf_addr, buf_din, buf_we
    );
endinterface

// File: rtl/jtkicker_objdraw.sv
// Sprite line drawer: takes one sprite-row command, fetches the row's
// 8 ROM bytes (16 pixels at 4bpp) and writes the opaque pixels into the
// object line buffer.
// Ports:
//   clk    : video clock
//   rst_n  : asynchronous active-low reset
//   obj_if : command, ROM handshake and line-buffer write signals (slave side)
module jtkicker_objdraw #(
    parameter int PALW  = 4,
    parameter int CODEW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    jtkicker_objdraw_if.slave obj_if
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAW0, DRAW1} state_t;

    state_t             state_q;
    logic [CODEW-1:0]   code_q;
    logic [3:0]         row_q;
    logic               hflip_q;
    logic [PALW-1:0]    pal_q;
    logic [2:0]         b_q;
    logic [7:0]         x_q;
    logic               settle_q;
    logic [3:0]         second_q;
    logic               busy_q;
    logic               rom_cs_q;
    logic [CODEW+6:0]   rom_addr_q;
    logic [7:0]         buf_addr_q;
    logic [PALW+3:0]    buf_din_q;
    logic               buf_we_q;

    logic [3:0]         cmd_row_d;
    logic [2:0]         cmd_idx_d;
    logic [2:0]         b_d;
    logic [2:0]         next_idx_d;
    logic [3:0]         first_nib_d;
    logic [3:0]         second_nib_d;

    always_comb begin
        cmd_row_d    = obj_if.vflip ? ~obj_if.ysub : obj_if.ysub;
        cmd_idx_d    = obj_if.hflip ? 3'd7 : 3'd0;
        b_d          = b_q + 3'd1;
        // 7-b on three bits is simply the bitwise inverse
        next_idx_d   = hflip_q ? ~b_d : b_d;
        // hflip mirrors the row, so the low nibble becomes the left pixel
        first_nib_d  = hflip_q ? obj_if.rom_data[3:0] : obj_if.rom_data[7:4];
        second_nib_d = hflip_q ? obj_if.rom_data[7:4] : obj_if.rom_data[3:0];
    end

    // The buffer outputs are loaded one cycle ahead of the state that owns
    // them, so the first pixel is on the bus while the FSM sits in DRAW0 and
    // the second while it sits in DRAW1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            code_q     <= '0;
            row_q      <= '0;
            hflip_q    <= 1'b0;
            pal_q      <= '0;
            b_q        <= '0;
            x_q        <= '0;
            settle_q   <= 1'b0;
            second_q   <= '0;
            busy_q     <= 1'b0;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            buf_addr_q <= '0;
            buf_din_q  <= '0;
            buf_we_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    buf_we_q <= 1'b0;
                    if (obj_if.draw) begin
                        code_q     <= obj_if.code;
                        row_q      <= cmd_row_d;
                        hflip_q    <= obj_if.hflip;
                        pal_q      <= obj_if.pal;
                        b_q        <= '0;
                        x_q        <= obj_if.xpos;
                        settle_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        rom_cs_q   <= 1'b1;
                        rom_addr_q <= {obj_if.code, cmd_row_d, cmd_idx_d};
                        state_q    <= FETCH;
                    end
                end
                FETCH: begin
                    // The first FETCH cycle lets the ROM slot see the new
                    // address before rom_ok is trusted.
                    if (settle_q) begin
                        settle_q <= 1'b0;
                    end else if (obj_if.rom_ok) begin
                        rom_cs_q   <= 1'b0;
                        second_q   <= second_nib_d;
                        buf_addr_q <= x_q;
                        buf_din_q  <= {pal_q, first_nib_d};
                        buf_we_q   <= (first_nib_d != 4'd0);
                        x_q        <= x_q + 8'd1;
                        state_q    <= DRAW0;
                    end
                end
                DRAW0: begin
                    buf_addr_q <= x_q;
                    buf_din_q  <= {pal_q, second_q};
                    buf_we_q   <= (second_q != 4'd0);
                    x_q        <= x_q + 8'd1;
                    state_q    <= DRAW1;
                end
                DRAW1: begin
                    buf_we_q <= 1'b0;
                    if (b_q == 3'd7) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        b_q        <= b_d;
                        settle_q   <= 1'b1;
                        rom_cs_q   <= 1'b1;
                        rom_addr_q <= {code_q, row_q, next_idx_d};
                        state_q    <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign obj_if.busy     = busy_q;
    assign obj_if.rom_cs   = rom_cs_q;
    assign obj_if.rom_addr = rom_addr_q;
    assign obj_if.buf_addr = buf_addr_q;
    assign obj_if.buf_din  = buf_din_q;
    assign obj_if.buf_we   = buf_we_q;

endmodule

// File: tb/tb_jtkicker_objdraw.sv
// Testbench for jtkicker_objdraw: directed rows plus randomized commands,
// each checked against a row-image reference model.
module tb_jtkicker_objdraw;
    localparam int PALW  = 4;
    localparam int CODEW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jtkicker_objdraw_if #(.PALW(PALW), .CODEW(CODEW)) obj_if();

    jtkicker_objdraw #(.PALW(PALW), .CODEW(CODEW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .obj_if (obj_if)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rom_mode = 0;
    logic [31:0] seed     = 32'h1234_5678;
    int          stall[8];
    int          force_byte = -1;
    int          force_len  = 0;

    // ROM contents as a pure function of the address
    function automatic logic [7:0] rom_fn(input logic [16:0] a, input int mode, input logic [31:0] s);
        logic [31:0] h;
        case (mode)
            1: return 8'(8'h12 + 8'h22 * {5'd0, a[2:0]});
            2: return 8'h0F;
            default: begin
                h = ({15'd0, a} * 32'h9E37_79B1) ^ s;
                h = h ^ (h >> 15);
                return h[7:0] & {(h[9] ? 4'h0 : 4'hF), (h[10] ? 4'h0 : 4'hF)};
            end
        endcase
    endfunction

    assign obj_if.rom_data = rom_fn(obj_if.rom_addr, rom_mode, seed);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     {31'd0, obj_if.busy},   0);
        check({tag, "_rom_cs"},   {31'd0, obj_if.rom_cs}, 0);
        check({tag, "_buf_we"},   {31'd0, obj_if.buf_we}, 0);
        check({tag, "_rom_addr"}, {15'd0, obj_if.rom_addr}, 0);
        check({tag, "_buf_addr"}, {24'd0, obj_if.buf_addr}, 0);
        check({tag, "_buf_din"},  {24'd0, obj_if.buf_din},  0);
    endtask

    // Issue one command at the current negedge and follow it to completion.
    task automatic run_cmd(input logic [9:0] code, input logic [7:0] xpos, input logic [3:0] ysub,
                           input logic hf, input logic vf, input logic [3:0] pal,
                           input bit noisy, input int max_stall);
        logic [3:0]  row;
        logic [16:0] ra[8];
        logic [7:0]  wx[$];
        logic [7:0]  wd[$];
        int          wc[$];
        int          cum, exp_busy, cyc, widx, ridx, age, q;
        bit          prev_cs, done;
        logic [7:0]  by;
        logic [3:0]  nib;

        // Reference: the row image, mirrored when hflip, drawn left to right
        row = vf ? 4'(4'd15 - ysub) : ysub;
        exp_busy = 32;
        for (int j = 0; j < 8; j++) begin
            if (j == force_byte) stall[j] = force_len;
            else if (max_stall > 0) stall[j] = int'($urandom_range(0, max_stall));
            else stall[j] = 0;
            exp_busy += stall[j];
            ra[j] = {code, row, 3'(hf ? 7 - j : j)};
        end
        cum = 0;
        for (int p = 0; p < 16; p++) begin
            q   = hf ? 15 - p : p;
            by  = rom_fn({code, row, 3'(q / 2)}, rom_mode, seed);
            nib = (q % 2 == 0) ? by[7:4] : by[3:0];
            if (p % 2 == 0) cum += stall[p / 2];
            if (nib != 4'd0) begin
                wx.push_back(8'(int'(xpos) + p));
                wd.push_back({pal, nib});
                wc.push_back(4 * (p / 2) + 3 + (p % 2) + cum);
            end
        end

        obj_if.draw  = 1'b1;
        obj_if.code  = code;
        obj_if.xpos  = xpos;
        obj_if.ysub  = ysub;
        obj_if.hflip = hf;
        obj_if.vflip = vf;
        obj_if.pal   = pal;
        cyc = 0; widx = 0; ridx = 0; age = 0; prev_cs = 1'b0; done = 1'b0;

        while (!done) begin
            @(negedge clk);
            cyc++;
            if (obj_if.rom_cs) begin
                if (!prev_cs) begin
                    if (ridx < 8) check("rom_addr", {15'd0, obj_if.rom_addr}, {15'd0, ra[ridx]});
                    else check("extra_fetch", 1, 0);
                    ridx++;
                    age = 0;
                end else if (ridx <= 8) begin
                    check("rom_addr_hold", {15'd0, obj_if.rom_addr}, {15'd0, ra[ridx-1]});
                    check("we_in_fetch", {31'd0, obj_if.buf_we}, 0);
                end
                // Settle cycle gets a random rom_ok, which must be ignored
                if (age == 0) obj_if.rom_ok = 1'($urandom);
                else obj_if.rom_ok = (ridx <= 8) ? (age >= 1 + stall[ridx-1]) : 1'b1;
                age++;
            end else begin
                obj_if.rom_ok = 1'($urandom);
            end
            prev_cs = obj_if.rom_cs;

            if (obj_if.buf_we) begin
                if (widx < wx.size()) begin
                    check("buf_addr", {24'd0, obj_if.buf_addr}, {24'd0, wx[widx]});
                    check("buf_din",  {24'd0, obj_if.buf_din},  {24'd0, wd[widx]});
                    check("write_cycle", cyc, wc[widx]);
                end else begin
                    check("extra_write", 1, 0);
                end
                widx++;
            end

            if (!obj_if.busy) begin
                done = 1'b1;
                obj_if.draw = 1'b0;
                check("busy_len", cyc - 1, exp_busy);
                check("n_writes", widx, wx.size());
                check("n_fetches", ridx, 8);
            end else if (cyc > 400) begin
                done = 1'b1;
                obj_if.draw = 1'b0;
                check("timeout_busy", {31'd0, obj_if.busy}, 0);
            end else if (noisy) begin
                obj_if.draw  = 1'($urandom);
                obj_if.code  = 10'($urandom);
                obj_if.xpos  = 8'($urandom);
                obj_if.ysub  = 4'($urandom);
                obj_if.hflip = 1'($urandom);
                obj_if.vflip = 1'($urandom);
                obj_if.pal   = 4'($urandom);
            end else begin
                obj_if.draw = 1'b0;
            end
        end
        $display("cmd code=%h x=%h ysub=%0d hf=%0d vf=%0d pal=%0d noisy=%0d writes=%0d busy=%0d",
                 code, xpos, ysub, hf, vf, pal, noisy, widx, cyc - 1);
    endtask

    // Start a row, then pull reset while a pixel write is on the bus.
    task automatic reset_mid_draw();
        int cyc;
        rom_mode = 1;
        obj_if.rom_ok = 1'b1;
        obj_if.draw  = 1'b1;
        obj_if.code  = 10'h155;
        obj_if.xpos  = 8'h10;
        obj_if.ysub  = 4'd3;
        obj_if.hflip = 1'b0;
        obj_if.vflip = 1'b0;
        obj_if.pal   = 4'd5;
        cyc = 0;
        while (!(obj_if.buf_we && cyc >= 7) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            obj_if.draw = 1'b0;
        end
        check("reset_setup_we", {31'd0, obj_if.buf_we}, 1);
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset_async");
        repeat (2) @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_we",   {31'd0, obj_if.buf_we}, 0);
            check("post_reset_busy", {31'd0, obj_if.busy},   0);
            check("post_reset_cs",   {31'd0, obj_if.rom_cs}, 0);
        end
        $display("reset mid-draw at cycle %0d", cyc);
    endtask

    initial begin
        obj_if.draw = 1'b0; obj_if.code = '0; obj_if.xpos = '0; obj_if.ysub = '0;
        obj_if.hflip = 1'b0; obj_if.vflip = 1'b0; obj_if.pal = '0; obj_if.rom_ok = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        seed = $urandom;

        rom_mode = 1;
        run_cmd(10'h155, 8'h10, 4'd3, 1'b0, 1'b0, 4'd5, 1'b0, 0);
        run_cmd(10'h155, 8'h10, 4'd3, 1'b1, 1'b1, 4'd5, 1'b0, 0);
        rom_mode = 2;
        run_cmd(10'h0A3, 8'hF8, 4'd9, 1'b0, 1'b0, 4'd2, 1'b0, 0);
        run_cmd(10'h0A3, 8'hFA, 4'd9, 1'b1, 1'b0, 4'd7, 1'b0, 0);
        rom_mode = 1;
        force_byte = 2; force_len = 5;
        run_cmd(10'h155, 8'h10, 4'd3, 1'b0, 1'b0, 4'd5, 1'b0, 0);
        force_byte = -1;
        run_cmd(10'h155, 8'h10, 4'd3, 1'b0, 1'b0, 4'd5, 1'b1, 0);
        reset_mid_draw();
        run_cmd(10'h155, 8'h10, 4'd3, 1'b0, 1'b0, 4'd5, 1'b0, 0);

        rom_mode = 0;
        for (int n = 0; n < 30; n++) begin
            run_cmd(10'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                    4'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
        end

        repeat (4) begin
            @(negedge clk);
            check("idle_we", {31'd0, obj_if.buf_we}, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
